instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front-end stage that produces the 32-bit `instruction` word consumed by `control_unit`.
- Owns the fetch program counter and issues word reads to instruction memory, with at most one request outstanding.
- Buffers returned words in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Accepts redirects from jump/branch resolution and discards stale fetches.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- DEPTH, 2, prefetch FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  32  word-aligned read address; stable while imem_req=1.
- imem_ack  input  1  read data valid; arrives >=1 cycle after request issue.
- imem_rdata  input  32  read data, sampled when imem_ack=1.
- instruction  output  32  instruction word at FIFO head, to control_unit.
- instr_pc  output  32  PC of `instruction`.
- instr_valid  output  1  FIFO head valid.
- instr_ready  input  1  decode accepts head this cycle (pop when valid & ready).
- redirect  input  1  taken jump/branch: flush and refetch.
- redirect_pc  input  32  new fetch address, sampled when redirect=1.
- fetch_fault  output  1  misaligned-redirect flag (only with the optional feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO emptied; state=RUN.
  - imem_req=0, instr_valid=0, instruction=0, instr_pc=0, fetch_fault=0.
- States:
  - RUN: no request outstanding.
  - WAIT: request outstanding, response wanted.
  - DRAIN: request outstanding, response to be discarded.
- RUN:
  - If count < DEPTH and redirect=0: assert imem_req=1 with imem_addr=fetch_pc for exactly one cycle, then go to WAIT.
  - Otherwise imem_req=0 and stay in RUN.
- WAIT on imem_ack=1:
  - Push {fetch_pc, imem_rdata}; fetch_pc += 4, wrapping modulo 2^32.
  - Go to RUN. The next request may issue in the following cycle, giving one request every 2 cycles at minimum.
- DRAIN on imem_ack=1: drop the data, do not push, go to RUN.
- Redirect (any state):
  - FIFO cleared in the same edge; fetch_pc = {redirect_pc[31:2], 2'b00}.
  - From WAIT, or from RUN while issuing, go to DRAIN. From RUN with nothing issued, stay in RUN.
  - In DRAIN a repeat redirect only updates fetch_pc.
  - Redirect has priority over a simultaneous pop, push or ack. An ack in the redirect cycle is discarded and the state goes to RUN rather than DRAIN.
  - instr_valid is 0 in the cycle after a redirect.
- FIFO:
  - Output is registered from the FIFO head: instruction, instr_pc and instr_valid reflect head contents combinationally from storage, with no added latency beyond the push edge.
  - Latency from ack to instr_valid=1 is 1 cycle.
  - Simultaneous push and pop when full is allowed; count is unchanged.
  - Push when full cannot occur, because issue is gated by count < DEPTH. Treat it as an assertion failure in simulation.
  - Pop when empty is ignored.
- Stall (instr_ready=0): head is held stable. Fetching continues until the FIFO is full.
- imem_ack while in RUN: ignored (protocol error, flagged by the bench).

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0] != 0 sets fetch_fault=1, which is sticky until reset.
  - Fetching halts: no further imem_req; the FIFO stays empty.
  - The PC is still loaded, aligned.
- Undefined:
  - fetch_fault is tied to 0.
  - Low bits are silently cleared and fetching continues.

Test Plan:
- Reset release, RESET_PC=0, ack 1 cycle after each req, instr_ready=1 -> imem_addr sequence 0x0,0x4,0x8; instr_pc matches; instruction equals the returned data.
- instr_ready=0 held for 10 cycles, ack latency 1 -> exactly DEPTH=2 requests; then imem_req stays 0 and the head is stable at pc 0x0.
- Redirect to 0x100 while WAIT on addr 0x8 -> the ack for 0x8 is dropped; the next imem_addr is 0x100; no instruction with pc 0x8 is ever valid.
- Redirect in the same cycle as an ack and a pop -> FIFO empty next cycle; next request at redirect_pc.
- fetch_pc=0xFFFF_FFFC with an ack -> next imem_addr is 0x0000_0000.
- MISALIGN_TRAP_EN defined, redirect_pc=0x102 -> fetch_fault=1 next cycle and no further imem_req. Undefined -> next imem_addr is 0x100 and fetch_fault stays 0.
- Assert reset=0 mid-WAIT -> all outputs are 0 immediately (asynchronous); after release the first imem_addr is RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Purpose  : Instruction fetch front end. Owns the fetch PC and issues
//             single-outstanding word reads to instruction memory. Returned
//             words go into a small prefetch FIFO that feeds decode through
//             a valid/ready handshake. A redirect flushes the FIFO, reloads
//             the fetch PC and discards any fetch still in flight.
//  Ports    : clk, reset (async, active-low)
//             imem_req / imem_addr / imem_ack / imem_rdata : memory side
//             instruction / instr_pc / instr_valid / instr_ready : decode side
//             redirect / redirect_pc : jump/branch resolution
//             fetch_fault : sticky misaligned-redirect flag
//  Options  : MISALIGN_TRAP_EN - when defined, a redirect whose target has
//             nonzero low bits sets fetch_fault and halts fetching until
//             reset. When undefined, the low bits are cleared silently and
//             fetch_fault is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    localparam int              c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(DEPTH);

    // RUN: nothing in flight. WAIT: response wanted. DRAIN: response stale.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_fetch_pc;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw:0]     r_count;
    logic [31:0]       r_mem_pc   [DEPTH];
    logic [31:0]       r_mem_data [DEPTH];

    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_halt;

    // ------------------------------------------------------------------
    // Misaligned-redirect trap
    // ------------------------------------------------------------------
`ifdef MISALIGN_TRAP_EN
    logic r_fault;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fault <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            r_fault <= 1'b1;
        end
    end

    assign w_halt      = r_fault;
    assign fetch_fault = r_fault;
`else
    // Low target bits are simply dropped when the trap is not built in.
    logic w_unused_lsbs;

    assign w_unused_lsbs = ^redirect_pc[1:0];
    assign w_halt        = 1'b0;
    assign fetch_fault   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Handshake qualifiers and next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // Gating on reset keeps imem_req low while reset is held, since the
        // state register sits in RUN with an empty FIFO during reset.
        w_issue      = (r_state == ST_RUN) && (r_count < c_depth) &&
                       !redirect && !w_halt && reset;
        // Redirect outranks ack and pop: both are squashed on that edge.
        w_push       = (r_state == ST_WAIT) && imem_ack && !redirect;
        w_pop        = (r_count != '0) && instr_ready && !redirect;
        w_state_next = r_state;

        case (r_state)
            ST_RUN: begin
                if (w_issue) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An ack landing with a redirect closes the transaction, so
                // there is nothing left to drain.
                if (imem_ack) begin
                    w_state_next = ST_RUN;
                end else if (redirect) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, fetch PC and FIFO pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_next;
            if (redirect) begin
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr   <= r_wr_ptr + 1'b1;
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // FIFO storage needs no reset: the head is masked by instr_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
            r_mem_data[r_wr_ptr] <= imem_rdata;
        end
    end

    // Issue is gated on occupancy, so a push into a full FIFO without a
    // matching pop means that gating has broken.
    always_ff @(posedge clk) begin
        if (reset && w_push && !w_pop) begin
            assert (r_count < c_depth);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req    = w_issue;
    assign imem_addr   = r_fetch_pc;
    assign instr_valid = (r_count != '0);
    assign instruction = instr_valid ? r_mem_data[r_rd_ptr] : 32'h0;
    assign instr_pc    = instr_valid ? r_mem_pc[r_rd_ptr]   : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Purpose  : Self-checking bench for instr_fetch_unit. The bench acts as an
//             instruction memory with programmable latency whose contents
//             are a hash of the address. Decode-side expectations come from
//             a simple program-order model: after reset or a redirect,
//             accepted instructions must appear at consecutive word
//             addresses starting from the (aligned) target.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard / model state
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          outstanding;
    logic [31:0] out_addr;
    int          lat_cnt;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] exp_pc;
    bit          prev_redir;
    logic [31:0] req_log [$];
    int          n_pops;
    logic [31:0] last_pop_pc;
    logic        last_valid;
    logic        last_req;
    logic [31:0] seed;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    task automatic model_clear();
        outstanding = 1'b0;
        out_addr    = 32'h0;
        lat_cnt     = 0;
        exp_pc      = RESET_PC;
        prev_redir  = 1'b0;
        req_log.delete();
        n_pops      = 0;
        last_pop_pc = 32'hDEAD_BEEF;
        last_valid  = 1'b0;
        last_req    = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One clock cycle: called at a falling edge, drives inputs, samples the
    // settled outputs, updates the memory model and the program-order model.
    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy);
        redirect    = redir;
        redirect_pc = rpc;
        instr_ready = rdy;
        if (outstanding && lat_cnt == 0) begin
            imem_ack    = 1'b1;
            imem_rdata  = mem_data(out_addr);
            outstanding = 1'b0;
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            if (outstanding) lat_cnt = lat_cnt - 1;
        end
        #1;
        if (prev_redir) begin
            n_tests++;
            if (instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL valid_after_redirect: got %b expected 0", instr_valid);
            end
        end
        if (instr_valid === 1'b1 && rdy && !redir) begin
            n_tests++;
            if (instr_pc !== exp_pc) begin
                n_fail++;
                $display("FAIL pop_pc: got %h expected %h", instr_pc, exp_pc);
            end
            n_tests++;
            if (instruction !== mem_data(exp_pc)) begin
                n_fail++;
                $display("FAIL pop_data: got %h expected %h (pc %h)",
                         instruction, mem_data(exp_pc), exp_pc);
            end
            exp_pc      = exp_pc + 32'd4;
            n_pops      = n_pops + 1;
            last_pop_pc = instr_pc;
        end
        if (imem_req === 1'b1) begin
            n_tests++;
            if (outstanding) begin
                n_fail++;
                $display("FAIL req_while_outstanding: got req addr %h expected no req (pending %h)",
                         imem_addr, out_addr);
            end
            outstanding = 1'b1;
            out_addr    = imem_addr;
            lat_cnt     = int'($urandom_range(lat_max, lat_min)) - 1;
            req_log.push_back(imem_addr);
        end
        if (redir) exp_pc = {rpc[31:2], 2'b00};
        prev_redir = redir;
        last_valid = instr_valid;
        last_req   = imem_req;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        n_tests++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        n_tests++;
        if (instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", instruction); end
        n_tests++;
        if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", instr_pc); end
        n_tests++;
        if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", fetch_fault); end
        n_tests++;
        if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RESET_PC); end
    endtask

    task automatic test_sequential();
        lat_min = 1; lat_max = 1;
        apply_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (req_log.size() != 4) begin n_fail++; $display("FAIL seq_req_count: got %0d expected 4", req_log.size()); end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (req_log[i] !== RESET_PC + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL seq_addr%0d: got %h expected %h", i, req_log[i], RESET_PC + 32'(4 * i));
            end
        end
        n_tests++;
        if (n_pops != 3) begin n_fail++; $display("FAIL seq_pops: got %0d expected 3", n_pops); end
    endtask

    task automatic test_stall();
        lat_min = 1; lat_max = 1;
        apply_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b0);
        n_tests++;
        if (req_log.size() != DEPTH) begin n_fail++; $display("FAIL stall_req_count: got %0d expected %0d", req_log.size(), DEPTH); end
        n_tests++;
        if (last_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_idle: got %b expected 0", last_req); end
        n_tests++;
        if (instr_valid !== 1'b1 || instr_pc !== RESET_PC) begin
            n_fail++;
            $display("FAIL stall_head: got valid %b pc %h expected valid 1 pc %h", instr_valid, instr_pc, RESET_PC);
        end
        n_tests++;
        if (instruction !== mem_data(RESET_PC)) begin n_fail++; $display("FAIL stall_data: got %h expected %h", instruction, mem_data(RESET_PC)); end
    endtask

    task automatic test_redirect_wait();
        lat_min = 3; lat_max = 3;
        apply_reset();
        for (int i = 0; i < 40 && req_log.size() < 3; i++) cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (req_log.size() < 3 || req_log[2] !== 32'h8) begin
            n_fail++;
            $display("FAIL rw_reach_8: got %0d reqs expected third req at 00000008", req_log.size());
        end
        cycle(1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 40 && last_pop_pc !== 32'h100; i++) cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (req_log.size() < 4 || req_log[3] !== 32'h100) begin
            n_fail++;
            $display("FAIL rw_next_addr: got %0d reqs expected fourth req at 00000100", req_log.size());
        end
        n_tests++;
        if (last_pop_pc !== 32'h100) begin n_fail++; $display("FAIL rw_target_popped: got %h expected 00000100", last_pop_pc); end
    endtask

    task automatic test_redirect_ack_pop();
        lat_min = 1; lat_max = 1;
        apply_reset();
        cycle(1'b0, 32'h0, 1'b1);     // request 0x0
        cycle(1'b0, 32'h0, 1'b1);     // ack 0x0
        cycle(1'b0, 32'h0, 1'b0);     // head held, request 0x4
        cycle(1'b1, 32'h200, 1'b1);   // ack 0x4 + pop + redirect together
        cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (last_valid !== 1'b0) begin n_fail++; $display("FAIL rap_empty: got valid %b expected 0", last_valid); end
        n_tests++;
        if (last_req !== 1'b1 || req_log[req_log.size()-1] !== 32'h200) begin
            n_fail++;
            $display("FAIL rap_next_addr: got req %b addr %h expected req 1 addr 00000200", last_req, req_log[req_log.size()-1]);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (n_pops < 2) begin n_fail++; $display("FAIL rap_resume: got %0d pops expected >=2", n_pops); end
    endtask

    task automatic test_wrap();
        lat_min = 1; lat_max = 1;
        apply_reset();
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_addr: got %0d reqs expected FFFFFFFC then 00000000", req_log.size());
        end
    endtask

    task automatic test_misalign();
        lat_min = 1; lat_max = 1;
        apply_reset();
        cycle(1'b1, 32'h102, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
`ifdef MISALIGN_TRAP_EN
        n_tests++;
        if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL mis_fault: got %b expected 1", fetch_fault); end
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (req_log.size() != 0) begin n_fail++; $display("FAIL mis_halt: got %0d reqs expected 0", req_log.size()); end
        n_tests++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mis_empty: got valid %b expected 0", instr_valid); end
`else
        n_tests++;
        if (req_log.size() < 1 || req_log[0] !== 32'h100) begin
            n_fail++;
            $display("FAIL mis_aligned_addr: got %0d reqs expected first at 00000100", req_log.size());
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL mis_fault_zero: got %b expected 0", fetch_fault); end
        n_tests++;
        if (last_pop_pc !== 32'h100 && last_pop_pc !== 32'h104) begin
            n_fail++;
            $display("FAIL mis_continue: got last pc %h expected 00000100 or 00000104", last_pop_pc);
        end
`endif
    endtask

    task automatic test_async_reset();
        lat_min = 4; lat_max = 4;
        apply_reset();
        for (int i = 0; i < 7; i++) cycle(1'b0, 32'h0, 1'b0);
        n_tests++;
        if (instr_valid !== 1'b1 || !outstanding) begin
            n_fail++;
            $display("FAIL ar_setup: got valid %b pending %b expected 1 1", instr_valid, outstanding);
        end
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instruction !== 32'h0 ||
            instr_pc !== 32'h0 || fetch_fault !== 1'b0 || imem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL ar_outputs: got req %b valid %b instr %h pc %h fault %b addr %h expected all 0 addr %h",
                     imem_req, instr_valid, instruction, instr_pc, fetch_fault, imem_addr, RESET_PC);
        end
        @(negedge clk);
        model_clear();
        lat_min = 1; lat_max = 1;
        reset = 1'b1;
        cycle(1'b0, 32'h0, 1'b1);
        n_tests++;
        if (req_log.size() < 1 || req_log[0] !== RESET_PC) begin
            n_fail++;
            $display("FAIL ar_first_addr: got %0d reqs expected first at %h", req_log.size(), RESET_PC);
        end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        bit          redir;
        bit          rdy;
        lat_min = 1; lat_max = 3;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            redir = ($urandom_range(0, 19) == 0);
            rpc   = $urandom;
            if ($urandom_range(0, 3) == 0) rpc[31:4] = 28'hFFF_FFFF;
            rpc[1:0] = 2'b00;
            rdy   = ($urandom_range(0, 3) != 0);
            cycle(redir, rpc, rdy);
        end
        n_tests++;
        if (n_pops < 50) begin n_fail++; $display("FAIL rand_progress: got %0d pops expected >=50", n_pops); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        seed        = $urandom;
        reset       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        model_clear();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_ack_pop();
        test_wrap();
        test_misalign();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
